// File: rtl/seq_gen_1011.sv
// Serial pattern transmitter: shifts PAT out MSB-first rep_cnt times, back-to-back or overlapped.
// Define SEQGEN_GAP_EN to insert one idle GAP cycle between back-to-back copies.
module seq_gen_1011 #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT    = 4'b1011,
    parameter int              OVL_LEN = 1,
    parameter int              CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic             ovl_mode,
    output logic             oup,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    // Bit-reversed copy so the bit index selects directly, MSB of PAT first.
    function automatic logic [PAT_W-1:0] reverse_bits(input logic [PAT_W-1:0] p);
        logic [PAT_W-1:0] r;
        for (int i = 0; i < PAT_W; i++) r[i] = p[PAT_W-1-i];
        return r;
    endfunction

    localparam logic [PAT_W-1:0] PAT_R = reverse_bits(PAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef SEQGEN_GAP_EN
        GAP   = 2'd2,
`endif
        DONE  = 2'd3
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [CNT_W-1:0] rem_q;
    logic             ovl_q;
    logic             oup_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             last_bit;

    assign last_bit = (idx_q == IDX_W'(PAT_W - 1));

    // NOTE: idx_d gets a value on every path so no latch is inferred.
    always_comb begin
        idx_d = idx_q + IDX_W'(1);
        if (last_bit) idx_d = ovl_q ? IDX_W'(OVL_LEN) : '0;
    end

    // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            ovl_q   <= 1'b0;
            oup_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (rep_cnt != '0)) begin
                        rem_q   <= rep_cnt;
                        ovl_q   <= ovl_mode;
                        idx_q   <= '0;
                        oup_q   <= PAT_R[0];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        idx_q <= idx_d;
                        oup_q <= PAT_R[idx_d];
                    end else if (rem_q == CNT_W'(1)) begin
                        idx_q   <= '0;
                        rem_q   <= '0;
                        oup_q   <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rem_q <= rem_q - CNT_W'(1);
`ifdef SEQGEN_GAP_EN
                        if (!ovl_q) begin
                            idx_q   <= '0;
                            oup_q   <= 1'b0;
                            valid_q <= 1'b0;
                            state_q <= GAP;
                        end else begin
                            idx_q <= idx_d;
                            oup_q <= PAT_R[idx_d];
                        end
`else
                        idx_q <= idx_d;
                        oup_q <= PAT_R[idx_d];
`endif
                    end
                end
`ifdef SEQGEN_GAP_EN
                GAP: begin
                    idx_q   <= '0;
                    oup_q   <= PAT_R[0];
                    valid_q <= 1'b1;
                    state_q <= SHIFT;
                end
`endif
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    oup_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oup   = oup_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_gen_1011.sv
// Table-driven bench for seq_gen_1011: expected per-cycle {oup,valid,busy,done} queued at start, popped each cycle.
module tb_seq_gen_1011;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] rep_cnt;
    logic             ovl_mode;
    logic             oup;
    logic             valid;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    seq_gen_1011 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rep_cnt  (rep_cnt),
        .ovl_mode (ovl_mode),
        .oup      (oup),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [CNT_W-1:0] rep;
        logic             ovl;
        string            stream;
        logic             exp_done;
        int               exp_det;
        int               pulse_at;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream chars: '1'/'0' pattern bit, '_' gap cycle; then optional done cycle and idle tail.
    task automatic push_stream(input string s, input logic with_done);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "1":     exp_q.push_back(4'b1110);
                "0":     exp_q.push_back(4'b0110);
                default: exp_q.push_back(4'b0010);
            endcase
        end
        if (with_done) exp_q.push_back(4'b0001);
        repeat (3) exp_q.push_back(4'b0000);
    endtask

    task automatic run_vec(input vec_t v);
        int         n;
        int         det;
        logic [3:0] hist;
        logic [3:0] e;
        det  = 0;
        hist = '0;
        @(negedge clk);
        start    = 1'b1;
        rep_cnt  = v.rep;
        ovl_mode = v.ovl;
        push_stream(v.stream, v.exp_done);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s cyc%0d {oup,valid,busy,done}", v.name, i), {28'd0, oup, valid, busy, done},
                  {28'd0, e});
            if (valid) begin
                hist = {hist[2:0], oup};
                if (hist == 4'b1011) det++;
            end
            if (i == v.pulse_at) begin
                start    = 1'b1;
                rep_cnt  = 4'd5;
                ovl_mode = 1'b1;
            end else begin
                start    = 1'b0;
                rep_cnt  = 4'($urandom_range(15));
                ovl_mode = 1'($urandom_range(1));
            end
        end
        start = 1'b0;
        check($sformatf("%s detections", v.name), det, v.exp_det);
    endtask

    initial begin
        string s15;
        reset    = 1'b0;
        start    = 1'b0;
        rep_cnt  = '0;
        ovl_mode = 1'b0;

        s15 = "1011";
        repeat (14) s15 = {s15, "011"};

        vecs[0] = '{"single",     4'd1,  1'b0, "1011",       1'b1, 1,  -1};
`ifdef SEQGEN_GAP_EN
        vecs[1] = '{"b2b3",       4'd3,  1'b0, "1011_1011_1011", 1'b1, 3, -1};
        vecs[4] = '{"repulse",    4'd2,  1'b0, "1011_1011",  1'b1, 2,  2};
`else
        vecs[1] = '{"b2b3",       4'd3,  1'b0, "101110111011", 1'b1, 3, -1};
        vecs[4] = '{"repulse",    4'd2,  1'b0, "10111011",   1'b1, 2,  2};
`endif
        vecs[2] = '{"ovl3",       4'd3,  1'b1, "1011011011", 1'b1, 3,  -1};
        vecs[3] = '{"zero",       4'd0,  1'b0, "",           1'b0, 0,  -1};
        vecs[5] = '{"done_start", 4'd1,  1'b1, "1011",       1'b1, 1,  4};
        vecs[6] = '{"ovl2",       4'd2,  1'b1, "1011011",    1'b1, 2,  -1};
        vecs[7] = '{"ovl15",      4'd15, 1'b1, s15,          1'b1, 15, -1};

        // Reset asserted at t=0: outputs must already be cleared before any edge.
        #1;
        check("reset t0 outputs", {28'd0, oup, valid, busy, done}, 32'd0);
        @(negedge clk);
        check("reset held outputs", {28'd0, oup, valid, busy, done}, 32'd0);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle no activity", {28'd0, oup, valid, busy, done}, 32'd0);
        end

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset mid-stream after the 6th bit of a rep=3 back-to-back transfer.
        @(negedge clk);
        start    = 1'b1;
        rep_cnt  = 4'd3;
        ovl_mode = 1'b0;
`ifdef SEQGEN_GAP_EN
        push_stream("1011_10", 1'b0);
        repeat (3) void'(exp_q.pop_back());
        for (int i = 0; i < 7; i++) begin
`else
        push_stream("101110", 1'b0);
        repeat (3) void'(exp_q.pop_back());
        for (int i = 0; i < 6; i++) begin
`endif
            @(negedge clk);
            start = 1'b0;
            check($sformatf("midrst cyc%0d {oup,valid,busy,done}", i), {28'd0, oup, valid, busy, done},
                  {28'd0, exp_q.pop_front()});
        end
        #2 reset = 1'b0;
        #1;
        check("midrst async clear", {28'd0, oup, valid, busy, done}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst held no done", {28'd0, oup, valid, busy, done}, 32'd0);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst waits for start", {28'd0, oup, valid, busy, done}, 32'd0);
        end
        run_vec('{"after_rst", 4'd1, 1'b0, "1011", 1'b1, 1, -1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_gen_1011.md
Name: seq_gen_1011

Overview:
- Serial pattern transmitter: the stimulus/transmit end of the 1011 sequence-detection path.
- On request, shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clk, repeated rep_cnt times.
- Copies are back-to-back or overlapped, where consecutive copies share OVL_LEN bits.
- Feeds serial-input detectors in the design and drives their benches.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
PAT, 4'b1011, pattern value, transmitted MSB first
OVL_LEN, 1, bits shared between consecutive copies in overlap mode (1 <= OVL_LEN < PAT_W; suffix of PAT equals prefix of PAT by construction)
CNT_W, 4, width of repetition count

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
start  input  1  request; sampled only in IDLE
rep_cnt  input  CNT_W  number of pattern copies; latched with start
ovl_mode  input  1  1 = overlapped copies, 0 = back-to-back; latched with start
oup  output  1  serial data bit, registered
valid  output  1  oup carries a pattern bit this cycle, registered
busy  output  1  transfer in progress (SHIFT or GAP), registered
done  output  1  one-cycle pulse after final bit, registered

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - oup=0, valid=0, busy=0, done=0.
  - Bit index and repetition counter are cleared.
- States: IDLE, SHIFT, GAP (GAP exists only with the macro), DONE.
- IDLE:
  - Outputs are 0.
  - start=1 and rep_cnt!=0 at edge N: latch rep_cnt and ovl_mode, go to SHIFT.
    - At the same edge, oup=PAT[PAT_W-1], valid=1, busy=1.
    - The first bit is therefore visible in the cycle after edge N (one-cycle latency).
  - start=1 with rep_cnt=0: ignored, no done pulse, stays in IDLE.
- SHIFT:
  - Each edge advances the bit index; oup=PAT[PAT_W-1-idx], valid=1.
  - When the last bit (idx=PAT_W-1) is being output:
    - If more copies remain and ovl_mode=1: the next edge outputs PAT[PAT_W-1-OVL_LEN] (idx restarts at OVL_LEN).
    - If more copies remain and ovl_mode=0: idx restarts at 0, or the block goes to GAP if the macro is enabled.
    - If this is the last copy: go to DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0, valid=0, oup=0.
  - Then IDLE.
  - start asserted while in DONE is ignored.
- Total valid bits:
  - Back-to-back: rep*PAT_W.
  - Overlapped: rep*PAT_W - (rep-1)*OVL_LEN.
  - valid stays high continuously across copies unless GAP is used.
- start, rep_cnt and ovl_mode changes while busy=1 are ignored; latched values hold for the whole transfer.
- Repetition counter:
  - Down-counter loaded with rep_cnt, decremented at each copy's last bit.
  - No wrap: reaching 1 on the last bit ends the transfer.
  - Maximum transfer is 2^CNT_W-1 copies.
- Reset mid-transfer: outputs clear immediately (asynchronously), with no done pulse. After reset is released, the block waits for a new start.
- oup is 0 whenever valid=0.

Optional Feature:
Macro SEQGEN_GAP_EN.
- Defined:
  - In back-to-back mode (ovl_mode=0), one GAP cycle is inserted between consecutive copies: oup=0, valid=0, busy=1.
  - No gap follows the last copy.
  - Overlap mode never inserts gaps.
  - Back-to-back length becomes rep*PAT_W + (rep-1) cycles.
- Undefined:
  - The GAP state and its logic are absent.
  - Copies are always contiguous.

Test Plan:
- Reset behaviour: reset=0 pulse at t=0 -> oup=0, valid=0, busy=0, done=0 before the first clk edge; no activity until start.
- Single copy: start=1, rep_cnt=1, ovl_mode=0 -> valid for 4 cycles with oup=1,0,1,1; then done=1 for exactly one cycle; busy falls with done.
- Back-to-back repeats: rep_cnt=3, ovl_mode=0 (macro off) -> 12 contiguous valid bits 101110111011; done once.
  - Macro on: 1011 _ 1011 _ 1011, 14 cycles with valid=0 in the gap cycles.
- Overlapped repeats: rep_cnt=3, ovl_mode=1 -> 10 valid bits 1011011011.
  - Loopback into the team's 1011 overlapping detector yields exactly 3 detections.
- Ignored requests:
  - rep_cnt=0 with start=1 -> no valid, no done.
  - start re-pulsed with rep_cnt=5 during a rep_cnt=2 transfer -> exactly 8 bits, single done.
- Reset mid-stream: assert reset=0 after the 6th bit of a rep_cnt=3 transfer -> oup/valid/busy go 0 immediately, no done.
  - After release, a new start with rep_cnt=1 produces a clean 1011.
